button_debouncer: RTL and testbench

Front end for the board push-buttons: takes N raw, active-low, asynchronous button pins and delivers clean, active-high, clock-synchronous levels. It also produces single-cycle press and release events. It sits between the board pins and downstream logic such as the LED gate logic, which then consumes the debounced levels instead of raw pins. Each channel is independent and identical.

---
 rtl/button_debouncer_if.sv | 23 ++
 rtl/button_debouncer.sv | 58 +++++
 tb/tb_button_debouncer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - raw button pins in, debounced levels and edge pulses out
interface button_debouncer_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_n,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_n,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel 2-flop synchronizer, stability counter and press/release pulses
module button_debouncer #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst_n,
    button_debouncer_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [N_BTN-1:0] cur;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [CNT_W-1:0] cnt [N_BTN];

    // Pins are active-low; everything past the synchronizer works active-high.
    assign cur = ~s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= '1;
            s2        <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= bus.btn_n;
            s2 <= s1;
            for (int i = 0; i < N_BTN; i++) begin
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;
                if (cur[i] == level_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    // Disagreement has persisted DEBOUNCE_CYCLES samples: accept it.
                    level_q[i]   <= cur[i];
                    cnt[i]       <= '0;
                    press_q[i]   <= cur[i];
                    release_q[i] <= ~cur[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed bench for button_debouncer with DEBOUNCE_CYCLES=4
module tb_button_debouncer;
    localparam int N = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_debouncer_if #(.N_BTN(N)) bus ();

    button_debouncer #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {level, press, release}.
    task automatic chk(input string tag, input logic [3*N-1:0] exp);
        logic [3*N-1:0] obs;
        obs = {bus.btn_level, bus.btn_press, bus.btn_release};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Every-cycle monitor: pulses must match level edges and be one cycle wide.
    logic rst_seen;
    logic [N-1:0] prev_level;
    logic [N-1:0] prev_press;
    logic [N-1:0] prev_rel;
    always @(posedge clk) rst_seen <= rst_n;
    always @(negedge clk) begin
        if (rst_seen === 1'b1) begin
            checks++;
            assert (bus.btn_press === (bus.btn_level & ~prev_level)) else begin
                failures++;
                $error("FAIL mon_press observed=%b expected=%b", bus.btn_press, bus.btn_level & ~prev_level);
            end
            checks++;
            assert (bus.btn_release === (~bus.btn_level & prev_level)) else begin
                failures++;
                $error("FAIL mon_release observed=%b expected=%b", bus.btn_release, ~bus.btn_level & prev_level);
            end
            checks++;
            assert (((bus.btn_press & prev_press) | (bus.btn_release & prev_rel)) === '0) else begin
                failures++;
                $error("FAIL mon_width press=%b release=%b expected=00", bus.btn_press & prev_press, bus.btn_release & prev_rel);
            end
        end
        prev_level = bus.btn_level;
        prev_press = bus.btn_press;
        prev_rel   = bus.btn_release;
    end

    initial begin
        rst_n = 1'b0;
        bus.btn_n = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset", 6'b00_00_00);
        end

        rst_n = 1'b1;
        bus.btn_n = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", 6'b00_00_00);
        end

        // Clean press on channel 0; tick k observes edge t0+k-1.
        bus.btn_n = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("press_wait", 6'b00_00_00);
        end
        tick();
        chk("press_edge", 6'b01_01_00);
        tick();
        chk("press_after", 6'b01_00_00);

        // Release on channel 0.
        bus.btn_n = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("release_wait", 6'b01_00_00);
        end
        tick();
        chk("release_edge", 6'b00_00_01);
        tick();
        chk("release_after", 6'b00_00_00);

        // Bounce 0,1,0,1 then hold low.
        for (int k = 0; k < 4; k++) begin
            bus.btn_n = (k % 2 == 0) ? 2'b10 : 2'b11;
            tick();
            chk("bounce", 6'b00_00_00);
        end
        bus.btn_n = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("bounce_hold", 6'b00_00_00);
        end
        tick();
        chk("bounce_edge", 6'b01_01_00);
        tick();
        chk("bounce_after", 6'b01_00_00);

        // Channel 1 low for exactly 3 samples: one short of acceptance.
        bus.btn_n = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("glitch_low", 6'b01_00_00);
        end
        bus.btn_n = 2'b10;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("glitch_after", 6'b01_00_00);
        end

        // Return channel 0 to released before the reset test.
        bus.btn_n = 2'b11;
        for (int k = 0; k < 10; k++) tick();
        chk("pre_reset_idle", 6'b00_00_00);

        // Reset mid-count.
        bus.btn_n = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("midcount_wait", 6'b00_00_00);
        end
        rst_n = 1'b0;
        tick();
        chk("midcount_reset", 6'b00_00_00);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("refill_wait", 6'b00_00_00);
        end
        tick();
        chk("refill_edge", 6'b01_01_00);
        tick();
        chk("refill_after", 6'b01_00_00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
